timekeeper: RTL and testbench

Parametrised, fully synchronous time-of-day and calendar core for the watch display path. It generates the one-second tick from `clk`, maintains sec/min/hour/day/month/year with month-length and leap-year rules, and supports in-place field setting with inc/dec and a blink strobe. It drives binary and BCD digit outputs to the mode multiplexer and seven-segment decoders. An optional alarm comparator is included.

---
 rtl/timekeeper.sv | 205 ++++++++++++++++++++
 tb/tb_timekeeper.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timekeeper.sv
// Time-of-day and calendar core: 1 s prescaler, carry chain, in-place field setting and blink.
// Define TIMEKEEPER_ALARM_EN to include the alarm comparator; otherwise alarm is tied to 0.
module timekeeper #(
    parameter int TICK_DIV  = 1000000,
    parameter int BLINK_DIV = 500000,
    parameter int YEAR_INIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [2:0]  field,
    input  logic        inc,
    input  logic        dec,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [6:0]  year,
    output logic [23:0] time_bcd,
    output logic [23:0] date_bcd,
    output logic        sec_pulse,
    output logic        blink,
    input  logic        alarm_en,
    input  logic [4:0]  alarm_hour,
    input  logic [5:0]  alarm_min,
    input  logic        alarm_ack,
    output logic        alarm
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

    function automatic logic [4:0] dmax_f(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dmax_f = 5'd30;
            4'd2:                    dmax_f = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            default:                 dmax_f = 5'd31;
        endcase
    endfunction

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        bcd2 = {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hour_q, hour_d, day_q, day_d;
    logic [3:0]    month_q, month_d;
    logic [6:0]    year_q, year_d;
    logic [23:0]   time_bcd_q, time_bcd_d, date_bcd_q, date_bcd_d;
    logic          sec_pulse_q, sec_pulse_d, blink_q, blink_d, set_q, set_d, alarm_q, alarm_d;
    logic          tick, step_up, step_dn;
    logic [4:0]    dmax_cur, dmax_new;

    assign dmax_cur = dmax_f(month_q, year_q);

    always_comb begin
        pcnt_d   = pcnt_q;
        tick     = 1'b0;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        day_d    = day_q;
        month_d  = month_q;
        year_d   = year_q;
        dmax_new = dmax_cur;
        bcnt_d   = bcnt_q;
        blink_d  = blink_q;
        set_d    = set_en;
        step_up  = inc & ~dec;
        step_dn  = dec & ~inc;

        if (set_en) begin
            pcnt_d = '0;
        end else if (pcnt_q == PCNT_MAX) begin
            pcnt_d = '0;
            tick   = 1'b1;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end

        if (set_en) begin
            // Setting wraps one field only; no carries
            if (step_up || step_dn) begin
                case (field)
                    3'd0: sec_d = step_up ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                                          : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
                    3'd1: min_d = step_up ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                                          : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
                    3'd2: hour_d = step_up ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1)
                                           : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
                    3'd3: day_d = step_up ? ((day_q >= dmax_cur) ? 5'd1 : day_q + 5'd1)
                                          : ((day_q <= 5'd1) ? dmax_cur : day_q - 5'd1);
                    3'd4: month_d = step_up ? ((month_q == 4'd12) ? 4'd1 : month_q + 4'd1)
                                            : ((month_q == 4'd1) ? 4'd12 : month_q - 4'd1);
                    3'd5: year_d = step_up ? ((year_q == 7'd99) ? 7'd0 : year_q + 7'd1)
                                           : ((year_q == 7'd0) ? 7'd99 : year_q - 7'd1);
                    default: ;
                endcase
            end
            dmax_new = dmax_f(month_d, year_d);
            if (day_d > dmax_new) day_d = dmax_new;
        end else if (tick) begin
            if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
            else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) min_d = min_q + 6'd1;
                else begin
                    min_d = 6'd0;
                    if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
                    else begin
                        hour_d = 5'd0;
                        if (day_q < dmax_cur) day_d = day_q + 5'd1;
                        else begin
                            day_d = 5'd1;
                            if (month_q != 4'd12) month_d = month_q + 4'd1;
                            else begin
                                month_d = 4'd1;
                                year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                            end
                        end
                    end
                end
            end
        end

        // Entering setting mode restarts the blink phase with the digits visible
        if (!set_en || !set_q) begin
            bcnt_d  = '0;
            blink_d = 1'b1;
        end else if (bcnt_q == BCNT_MAX) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end

        sec_pulse_d = tick;
        time_bcd_d  = {bcd2({2'b0, hour_d}), bcd2({1'b0, min_d}), bcd2({1'b0, sec_d})};
        date_bcd_d  = {bcd2(year_d), bcd2({3'b0, month_d}), bcd2({2'b0, day_d})};
    end

`ifdef TIMEKEEPER_ALARM_EN
    always_comb begin
        alarm_d = alarm_q;
        if (!alarm_en || alarm_ack)
            alarm_d = 1'b0;
        else if (tick && hour_d == alarm_hour && min_d == alarm_min && sec_d == 6'd0)
            alarm_d = 1'b1;
    end
`else
    logic unused_alarm_in;
    assign unused_alarm_in = ^{alarm_en, alarm_hour, alarm_min, alarm_ack, alarm_q};
    assign alarm_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q      <= '0;
            bcnt_q      <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= 7'(YEAR_INIT);
            time_bcd_q  <= '0;
            date_bcd_q  <= {bcd2(7'(YEAR_INIT)), 8'h01, 8'h01};
            sec_pulse_q <= 1'b0;
            blink_q     <= 1'b0;
            set_q       <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            bcnt_q      <= bcnt_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            time_bcd_q  <= time_bcd_d;
            date_bcd_q  <= date_bcd_d;
            sec_pulse_q <= sec_pulse_d;
            blink_q     <= blink_d;
            set_q       <= set_d;
            alarm_q     <= alarm_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign time_bcd  = time_bcd_q;
    assign date_bcd  = date_bcd_q;
    assign sec_pulse = sec_pulse_q;
    assign blink     = blink_q;
    assign alarm     = alarm_q;
endmodule

// File: tb/tb_timekeeper.sv
// Bench for timekeeper: calendar-level reference model, directed scenarios and random stimulus.
module tb_timekeeper;
    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;
    localparam int YEAR_INIT = 15;

    logic clk = 0, rst = 1, set_en = 0, inc = 0, dec = 0, alarm_en = 0, alarm_ack = 0;
    logic [2:0]  field = 0;
    logic [4:0]  alarm_hour = 0;
    logic [5:0]  alarm_min = 0;
    logic [5:0]  sec, min;
    logic [4:0]  hour, day;
    logic [3:0]  month;
    logic [6:0]  year;
    logic [23:0] time_bcd, date_bcd;
    logic        sec_pulse, blink, alarm;

    timekeeper #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .YEAR_INIT(YEAR_INIT)) dut (
        .clk(clk), .rst(rst), .set_en(set_en), .field(field), .inc(inc), .dec(dec),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .time_bcd(time_bcd), .date_bcd(date_bcd), .sec_pulse(sec_pulse), .blink(blink),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_ack(alarm_ack), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Reference model: plain calendar arithmetic
    int m_sec, m_min, m_hour, m_day, m_month, m_year, m_run, m_setcyc;
    bit m_pulse, m_blink, m_alarm, m_prev_set;
    int mdays[1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    function automatic int dim(input int mo, input int yr);
        dim = (mo == 2 && yr % 4 == 0) ? 29 : mdays[mo];
    endfunction

    function automatic int bcd(input int v);
        bcd = (v / 10) * 16 + v % 10;
    endfunction

    function automatic logic [83:0] exp_vec();
        exp_vec = {m_pulse, m_blink, m_alarm, 5'(m_hour), 6'(m_min), 6'(m_sec), 4'(m_month),
                   5'(m_day), 7'(m_year), 8'(bcd(m_hour)), 8'(bcd(m_min)), 8'(bcd(m_sec)),
                   8'(bcd(m_year)), 8'(bcd(m_month)), 8'(bcd(m_day))};
    endfunction

    function automatic logic [83:0] obs_vec();
        obs_vec = {sec_pulse, blink, alarm, hour, min, sec, month, day, year, time_bcd, date_bcd};
    endfunction

    function automatic int mval(input int f);
        case (f)
            0: mval = m_sec;
            1: mval = m_min;
            2: mval = m_hour;
            3: mval = m_day;
            4: mval = m_month;
            default: mval = m_year;
        endcase
    endfunction

    task automatic model_tick();
        int s;
        s = m_hour * 3600 + m_min * 60 + m_sec + 1;
        if (s == 86400) begin
            s = 0;
            m_day++;
            if (m_day > dim(m_month, m_year)) begin
                m_day = 1;
                m_month++;
                if (m_month > 12) begin
                    m_month = 1;
                    m_year = (m_year + 1) % 100;
                end
            end
        end
        m_hour = s / 3600;
        m_min  = (s / 60) % 60;
        m_sec  = s % 60;
    endtask

    task automatic model_edge();
        bit tick;
        int d;
        if (rst) begin
            m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_month = 1; m_year = YEAR_INIT;
            m_run = 0; m_setcyc = 0; m_pulse = 0; m_blink = 0; m_alarm = 0; m_prev_set = 0;
            return;
        end
        tick = 0;
        if (set_en) m_run = 0;
        else begin
            m_run++;
            if (m_run == TICK_DIV) begin tick = 1; m_run = 0; end
        end
        m_pulse = tick;
        if (set_en) begin
            m_setcyc = m_prev_set ? m_setcyc + 1 : 0;
            m_blink = ((m_setcyc / BLINK_DIV) % 2) == 0;
        end else m_blink = 1;
        m_prev_set = set_en;
        if (set_en && (inc ^ dec)) begin
            d = inc ? 1 : -1;
            case (field)
                0: m_sec = (m_sec + d + 60) % 60;
                1: m_min = (m_min + d + 60) % 60;
                2: m_hour = (m_hour + d + 24) % 24;
                3: m_day = (m_day - 1 + d + dim(m_month, m_year)) % dim(m_month, m_year) + 1;
                4: m_month = (m_month - 1 + d + 12) % 12 + 1;
                5: m_year = (m_year + d + 100) % 100;
                default: ;
            endcase
            if (m_day > dim(m_month, m_year)) m_day = dim(m_month, m_year);
        end else if (tick) model_tick();
`ifdef TIMEKEEPER_ALARM_EN
        if (!alarm_en || alarm_ack) m_alarm = 0;
        else if (tick && m_hour == alarm_hour && m_min == alarm_min && m_sec == 0) m_alarm = 1;
`else
        m_alarm = 0;
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_to(input int f, input int target);
        set_en = 1; field = 3'(f); dec = 0;
        for (int k = 0; k < 110 && mval(f) != target; k++) begin inc = 1; cyc(); end
        inc = 0;
    endtask

    task automatic test_reset();
        rst = 1; set_en = 1; field = 3'd0; inc = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset cyc %0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({hour, min, sec, day, month, year, blink, date_bcd} !== {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 7'd15, 1'b0, 24'h150101}) begin
            errors++; $display("FAIL reset_const got=%h %h %h %h %h %h %b %h", hour, min, sec, day, month, year, blink, date_bcd);
        end
        // reset in the middle of setting mode
        rst = 0; inc = 0;
        set_to(1, 7);
        rst = 1;
        cyc();
        checks++;
        if (obs_vec() !== exp_vec() || blink !== 1'b0 || min !== 6'd0) begin
            errors++; $display("FAIL reset_in_set got=%h exp=%h", obs_vec(), exp_vec());
        end
        set_en = 0;
    endtask

    task automatic test_tick();
        int pulses;
        pulses = 0;
        rst = 1; set_en = 0; cyc(); rst = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            pulses += int'(sec_pulse);
            checks++;
            if (obs_vec() !== exp_vec() || sec_pulse !== (i % 4 == 0)) begin
                errors++; $display("FAIL tick cyc %0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (sec !== 6'd4 || time_bcd !== 24'h000004 || pulses != 4) begin
            errors++; $display("FAIL tick_const sec=%0d bcd=%h pulses=%0d exp 4 000004 4", sec, time_bcd, pulses);
        end
    endtask

    task automatic test_setting();
        set_to(5, 16); set_to(4, 3); set_to(3, 31);
        field = 3'd4; dec = 1; cyc(); dec = 0;
        checks++;
        if (obs_vec() !== exp_vec() || month !== 4'd2 || day !== 5'd29) begin
            errors++; $display("FAIL set_month_clamp got m=%0d d=%0d exp m=2 d=29", month, day);
        end
        set_to(0, 17);
        field = 3'd0; inc = 1; dec = 1; cyc();
        checks++;
        if (obs_vec() !== exp_vec() || sec !== 6'd17) begin
            errors++; $display("FAIL set_inc_dec got sec=%0d exp 17", sec);
        end
        field = 3'd6; inc = 1; dec = 0; cyc(); inc = 0;
        checks++;
        if (obs_vec() !== exp_vec() || {sec, day, month, year} !== {6'd17, 5'd29, 4'd2, 7'd16}) begin
            errors++; $display("FAIL set_field6 got=%h exp=%h", obs_vec(), exp_vec());
        end
        field = 3'd3; dec = 1; for (int i = 0; i < 29; i++) cyc(); dec = 0;
        checks++;
        if (obs_vec() !== exp_vec() || day !== 5'd29) begin
            errors++; $display("FAIL set_day_wrap got d=%0d exp 29", day);
        end
        set_en = 0;
    endtask

    task automatic test_leap();
        for (int pass = 0; pass < 2; pass++) begin
            set_to(5, pass == 0 ? 16 : 15); set_to(4, 2); set_to(3, pass == 0 ? 29 : 28);
            set_to(2, 23); set_to(1, 59); set_to(0, 59);
            set_en = 0;
            for (int i = 0; i < TICK_DIV; i++) begin
                cyc();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL leap%0d cyc %0d got=%h exp=%h", pass, i, obs_vec(), exp_vec());
                end
            end
            checks++;
            if (day !== 5'd1 || month !== 4'd3 || time_bcd !== 24'h0) begin
                errors++; $display("FAIL leap%0d_const got d=%0d m=%0d t=%h exp 1 3 000000", pass, day, month, time_bcd);
            end
        end
    endtask

    task automatic test_rollover();
        int pulses;
        pulses = 0;
        set_to(5, 99); set_to(4, 12); set_to(3, 31); set_to(2, 23); set_to(1, 59); set_to(0, 59);
        set_en = 0;
        for (int i = 0; i < TICK_DIV; i++) begin
            cyc();
            pulses += int'(sec_pulse);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rollover cyc %0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (time_bcd !== 24'h0 || date_bcd !== 24'h000101 || pulses != 1) begin
            errors++; $display("FAIL rollover_const got t=%h d=%h p=%0d exp 000000 000101 1", time_bcd, date_bcd, pulses);
        end
    endtask

    task automatic test_freeze_blink();
        int first, toggles;
        logic prev;
        first = -1; toggles = 0;
        set_en = 1; cyc(); prev = blink;
        for (int i = 1; i < 3 * TICK_DIV; i++) begin
            cyc();
            if (blink !== prev) toggles++;
            prev = blink;
            checks++;
            if (obs_vec() !== exp_vec() || sec_pulse !== 1'b0) begin
                errors++; $display("FAIL freeze cyc %0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (toggles != (3 * TICK_DIV - 1) / BLINK_DIV) begin
            errors++; $display("FAIL blink_toggles got=%0d exp=%0d", toggles, (3 * TICK_DIV - 1) / BLINK_DIV);
        end
        set_en = 0;
        for (int i = 1; i <= TICK_DIV + 1; i++) begin
            cyc();
            if (sec_pulse === 1'b1 && first < 0) first = i;
            checks++;
            if (obs_vec() !== exp_vec() || blink !== 1'b1) begin
                errors++; $display("FAIL release cyc %0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (first != TICK_DIV) begin
            errors++; $display("FAIL first_tick got=%0d exp=%0d", first, TICK_DIV);
        end
    endtask

    task automatic test_alarm();
        alarm_en = 1; alarm_ack = 0; alarm_hour = 5'd0; alarm_min = 6'd1;
        set_to(2, 0); set_to(1, 0); set_to(0, 59);
        set_en = 0;
        for (int i = 0; i < TICK_DIV + 3; i++) begin
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL alarm cyc %0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
`ifdef TIMEKEEPER_ALARM_EN
        if (alarm !== 1'b1 || min !== 6'd1) begin
            errors++; $display("FAIL alarm_set got=%b exp=1", alarm);
        end
`else
        if (alarm !== 1'b0) begin
            errors++; $display("FAIL alarm_off got=%b exp=0", alarm);
        end
`endif
        alarm_ack = 1; cyc(); alarm_ack = 0;
        checks++;
        if (obs_vec() !== exp_vec() || alarm !== 1'b0) begin
            errors++; $display("FAIL alarm_ack got=%b exp=0", alarm);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 11) == 0) set_en = ~set_en;
            field = 3'($urandom_range(0, 7));
            inc = ($urandom_range(0, 2) == 0);
            dec = ($urandom_range(0, 2) == 0);
            alarm_en = ($urandom_range(0, 15) != 0);
            alarm_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                alarm_hour = 5'(m_hour); alarm_min = 6'(m_min + 1);
            end
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        rst = 0; inc = 0; dec = 0; set_en = 0; alarm_ack = 0;
    endtask

    initial begin
        test_reset();
        test_tick();
        test_setting();
        test_leap();
        test_rollover();
        test_freeze_blink();
        test_alarm();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
